// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: widths, instruction field slices, opcodes,
// and the state type of the fetch in-flight read slot.
package fetch_pkg;

  localparam int INSTR_W    = 20;
  localparam int ADDR_W     = 8;
  localparam int FIFO_DEPTH = 2;
  localparam int RESET_PC   = 0;

  // Instruction field slices
  localparam int OPC_MSB = 19;
  localparam int OPC_LSB = 16;
  localparam int RA_MSB  = 15;
  localparam int RA_LSB  = 12;
  localparam int RB_MSB  = 11;
  localparam int RB_LSB  = 8;
  localparam int RC_MSB  = 7;
  localparam int RC_LSB  = 4;

  localparam logic [3:0]         OP_STORE  = 4'b1100;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 20'h00000;

  // In-flight read slot: IDLE (nothing outstanding) or PENDING (data returns next cycle)
  typedef enum logic {
    SLOT_IDLE    = 1'b0,
    SLOT_PENDING = 1'b1
  } slot_state_e;

  function automatic logic [3:0] instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer for the fetch stage: DEPTH entries of {pc, instr}.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// push and pop in the same cycle are both performed; flush empties the buffer.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 28,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [PTR_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;

  // Pointer and storage update; flush has priority over push/pop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
        wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
      end
    end
  end

  // Status from pointer comparison: same index with differing wrap bit means full
  always_comb begin
    rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];
    count_o = wr_ptr_q - rd_ptr_q;
    empty_o = (wr_ptr_q == rd_ptr_q);
    full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
              (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, issues reads to a 1-cycle-latency instruction
// memory and buffers returned words so decode stalls never lose one.
// A redirect flushes the buffer and kills the outstanding read.
// Optional feature macro: FETCH_STALL_CNT_EN adds the stall_cycles counter output.
//
// Handshake: imem_req is a strobe, imem_data is valid exactly one cycle after it.
// Toward decode, an instruction transfers on any rising edge where
// instr_valid=1 and stall=0; instr_out/pc_out stay stable while stalled.
module instruction_fetch_unit #(
  parameter int INSTR_W    = fetch_pkg::INSTR_W,
  parameter int ADDR_W     = fetch_pkg::ADDR_W,
  parameter int FIFO_DEPTH = fetch_pkg::FIFO_DEPTH,
  parameter int RESET_PC   = fetch_pkg::RESET_PC
) (
  input  logic                   clock,
  input  logic                   reset_n,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]     imem_data,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   instr_valid,
  output logic [INSTR_W-1:0]     instr_out,
  output logic [ADDR_W-1:0]      pc_out,
  output fetch_pkg::slot_state_e dbg_slot_state
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cycles
`endif
);

  import fetch_pkg::*;

  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int OCC_W   = PTR_W + 2;

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_d;
  logic [ADDR_W-1:0]  slot_pc_q;
  slot_state_e        slot_q;
  logic               run_q;

  logic               pending;
  logic               pop;
  logic               push;
  logic               issue;
  logic [OCC_W-1:0]   occ;

  logic [ENTRY_W-1:0] fifo_rdata;
  logic [PTR_W:0]     fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i ({slot_pc_q, imem_data}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Issue decision: reserve a buffer slot for every read so a response never drops
  always_comb begin
    pending     = (slot_q == SLOT_PENDING);
    instr_valid = !fifo_empty;
    pop         = instr_valid && !stall;
    push        = pending && !redirect_valid && (!fifo_full || pop);
    occ         = OCC_W'(fifo_count) + OCC_W'(pending) - OCC_W'(pop);
    issue       = run_q && !redirect_valid && (occ < OCC_W'(FIFO_DEPTH));
    pc_d        = pc_q;
    if (redirect_valid) pc_d = redirect_pc;
    else if (issue)     pc_d = pc_q + ADDR_W'(1);
  end

  // Decode-facing outputs show NOP/0 whenever the buffer is empty
  always_comb begin
    imem_req       = issue;
    imem_addr      = pc_q;
    instr_out      = instr_valid ? fifo_rdata[INSTR_W-1:0] : NOP_INSTR;
    pc_out         = instr_valid ? fifo_rdata[ENTRY_W-1:INSTR_W] : '0;
    dbg_slot_state = slot_q;
  end

  // PC register and in-flight slot FSM; a redirect returns the slot to IDLE (kill)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= ADDR_W'(RESET_PC);
      slot_q    <= SLOT_IDLE;
      slot_pc_q <= '0;
      run_q     <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      run_q <= 1'b1;
      case (slot_q)
        SLOT_IDLE:    slot_q <= issue ? SLOT_PENDING : SLOT_IDLE;
        SLOT_PENDING: slot_q <= issue ? SLOT_PENDING : SLOT_IDLE;
        default:      slot_q <= SLOT_IDLE;
      endcase
      if (issue) slot_pc_q <= pc_q;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles decode held a valid instruction; only reset clears it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (instr_valid && stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a random phase,
// checked every cycle against a queue-based reference model of the fetch path.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  localparam int AW    = 8;
  localparam int IW    = 20;
  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          stall;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid;
  logic [IW-1:0] instr_out;
  logic [AW-1:0] pc_out;
  slot_state_e   dbg_slot_state;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0]   stall_cycles;
`endif

  instruction_fetch_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .dbg_slot_state (dbg_slot_state)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  // ---------------- memory contents and reference model ----------------
  logic [IW-1:0]    mem [256];
  logic [AW+IW-1:0] exp_q[$];     // buffered {pc, instr} the decode stage should see
  bit               m_pend;       // a read is outstanding
  logic [AW-1:0]    m_pend_pc;
  logic [AW-1:0]    m_pc;
  bit               m_started;
  int unsigned      m_stall_cnt;

  logic             last_req;
  logic [AW-1:0]    last_addr;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_pop();
    return (exp_q.size() > 0) && !stall;
  endfunction

  function automatic bit m_issue();
    int occupancy;
    occupancy = int'(exp_q.size()) + int'(m_pend) - int'(m_pop());
    return m_started && !redirect_valid && (occupancy < DEPTH);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pend      = 0;
    m_pend_pc   = '0;
    m_pc        = '0;
    m_started   = 0;
    m_stall_cnt = 0;
  endtask

  // Advance the model across one rising edge using this cycle's inputs
  task automatic model_update();
    bit pop;
    bit iss;
    pop = m_pop();
    iss = m_issue();
    if ((exp_q.size() > 0) && stall && (m_stall_cnt < 65535)) m_stall_cnt++;
    if (redirect_valid) begin
      exp_q.delete();
      m_pend = 0;
      m_pc   = redirect_pc;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (m_pend) exp_q.push_back({m_pend_pc, mem[m_pend_pc]});
      m_pend = iss;
      if (iss) begin
        m_pend_pc = m_pc;
        m_pc      = m_pc + 8'd1;
      end
    end
    m_started = 1;
  endtask

  task automatic check_outputs();
    bit            v;
    logic [IW-1:0] e_instr;
    logic [AW-1:0] e_pc;
    v       = exp_q.size() > 0;
    e_instr = v ? exp_q[0][IW-1:0] : '0;
    e_pc    = v ? exp_q[0][AW+IW-1:IW] : '0;
    chk("imem_req",    32'(imem_req),    32'(m_issue()));
    chk("imem_addr",   32'(imem_addr),   32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(v));
    chk("instr_out",   32'(instr_out),   32'(e_instr));
    chk("pc_out",      32'(pc_out),      32'(e_pc));
    chk("slot_state",  32'(dbg_slot_state), 32'(m_pend ? SLOT_PENDING : SLOT_IDLE));
`ifdef FETCH_STALL_CNT_EN
    chk("stall_cycles", 32'(stall_cycles), m_stall_cnt);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge with inputs already set; returns at the next falling edge
  task automatic step();
    #1;
    check_outputs();
    last_req  = imem_req;
    last_addr = imem_addr;
    @(posedge clock);
    model_update();
    @(negedge clock);
    imem_data = last_req ? mem[last_addr] : IW'($urandom);
  endtask

  // Short asynchronous reset pulse placed between a falling and the next rising edge
  task automatic pulse_reset();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_imem_req",    32'(imem_req),    32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr_out",   32'(instr_out),   32'd0);
    chk("rst_pc_out",      32'(pc_out),      32'd0);
    check_outputs();
    #2 reset_n = 1'b1;
    last_req = 1'b0;
    @(posedge clock);
    model_update();
    @(negedge clock);
    imem_data = IW'($urandom);
  endtask

  // ---------------- stimulus ----------------
  logic [IW-1:0] held;
  logic [AW-1:0] seen_pc [4];
  int            seen;
  bit            found;
  logic [AW-1:0] t4_exp [4];

  initial begin
    reset_n        = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_data      = '0;
    for (int a = 0; a < 256; a++)
      mem[a] = (a < 'h40) ? IW'(a + 'h100) : IW'($urandom);
    model_reset();
    @(negedge clock);

    // T1: reset release, free-running stream
    pulse_reset();
    step();
    step();
    #1;
    chk("t1_first_valid", 32'(instr_valid), 32'd1);
    chk("t1_first_instr", 32'(instr_out),   32'h00100);
    chk("t1_first_pc",    32'(pc_out),      32'h0);
    for (int i = 0; i < 10; i++) step();

    // T2: hold stall for 5 cycles, buffer fills and fetch stops
    stall = 1'b1;
    step();
    held = instr_out;
    for (int i = 0; i < 3; i++) step();
    #1;
    chk("t2_req_dropped", 32'(imem_req),    32'd0);
    chk("t2_full_valid",  32'(instr_valid), 32'd1);
    chk("t2_head_stable", 32'(instr_out),   32'(held));
    step();
    stall = 1'b0;
    step();

    // T3: redirect with one read outstanding and the buffer occupied
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    stall          = 1'b1;
    step();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    #1;
    chk("t3_req_after",  32'(imem_req),  32'd1);
    chk("t3_addr_after", 32'(imem_addr), 32'h40);
    found = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (!found && instr_valid) begin
        found = 1;
        chk("t3_first_pc", 32'(pc_out), 32'h40);
      end
    end
    chk("t3_found_valid", 32'(found), 32'd1);

    // T4: redirect near the top of the address space, PC wraps
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFE;
    step();
    redirect_valid = 1'b0;
    t4_exp[0] = 8'hFE; t4_exp[1] = 8'hFF; t4_exp[2] = 8'h00; t4_exp[3] = 8'h01;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (instr_valid && seen < 4) begin
        seen_pc[seen] = pc_out;
        seen++;
      end
    end
    chk("t4_count", 32'(seen), 32'd4);
    for (int i = 0; i < 4; i++) chk("t4_pc_seq", 32'(seen_pc[i]), 32'(t4_exp[i]));

    // Random phase: stalls, isolated and back-to-back redirects
    for (int i = 0; i < 300; i++) begin
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = AW'($urandom_range(0, 255));
      step();
    end
    stall          = 1'b0;
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // T5: asynchronous reset mid-stream, restart from the reset PC
    pulse_reset();
    #1;
    chk("t5_restart_req",  32'(imem_req),  32'd1);
    chk("t5_restart_addr", 32'(imem_addr), 32'h0);
    for (int i = 0; i < 4; i++) step();

`ifdef FETCH_STALL_CNT_EN
    // T6: stall counter counts valid-and-stalled cycles and saturates
    stall = 1'b1;
    for (int i = 0; i < 7; i++) step();
    #1;
    chk("t6_stall7", 32'(stall_cycles), 32'd7);
    for (int i = 0; i < 65535; i++) step();
    #1;
    chk("t6_saturate", 32'(stall_cycles), 32'hFFFF);
    stall = 1'b0;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
